alu_result_uart_tx: RTL and testbench
=====================================

# alu_result_uart_tx

Downstream stage of the 4-bit ALU top level. It captures each 8-bit ALU result (the `uo_out` byte) on a valid strobe into a small FIFO. It then transmits the results one at a time as 8N1 UART frames on a single pin, so results can be logged off-chip without sampling `uo_out` in parallel. Results are sent LSB first, in capture order.

## Interface

Parameters:
- `CLKS_PER_BIT`, default 16: clock cycles per UART bit. Legal values are 2 and above.
- `FIFO_DEPTH`, default 4: result FIFO entries. Must be a power of 2, 2 or more.

Ports:
- `clk`  in  1: single clock. All state changes on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `ena`  in  1: design enable. When low, pushes are ignored. A frame already in flight still completes, and the FIFO still drains.
- `res_in`  in  8: ALU result byte to capture.
- `res_valid`  in  1: capture request for `res_in`.
- `res_ready`  out  1: FIFO can accept data. Equal to `(fifo_count < FIFO_DEPTH)`.
- `tx`  out  1: UART serial output. Idle level is high.
- `busy`  out  1: high when the FSM is not in IDLE.
- `overflow`  out  1: sticky flag, set when a result is dropped. Cleared only by reset.
- `fifo_count`  out  $clog2(FIFO_DEPTH)+1: number of occupied FIFO entries.

## Operation

- Reset (asynchronous, effective immediately):
  - `tx`=1, `busy`=0, `overflow`=0, `fifo_count`=0, `res_ready`=1.
  - FSM goes to IDLE; read and write pointers, baud counter and bit index go to 0.
- Push condition: `res_valid && ena`.
  - Accepted if `fifo_count < FIFO_DEPTH`, or if a pop happens in the same cycle.
  - Otherwise the byte is dropped and `overflow` is set on that edge.
- Pop:
  - Happens only on a transition into START. The popped byte is loaded into an 8-bit shift register.
  - Simultaneous push and pop leaves `fifo_count` unchanged.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE → START when `fifo_count > 0`. Pops the FIFO; baud counter goes to 0.
  - START: `tx`=0 for `CLKS_PER_BIT` cycles, then → DATA with bit index 0.
  - DATA: `tx`=shift[0] for `CLKS_PER_BIT` cycles per bit, LSB first. The register shifts right after each bit. After bit 7 → STOP.
  - STOP: `tx`=1 for `CLKS_PER_BIT` cycles. At the end:
    - → START with an immediate pop if `fifo_count > 0`, giving back-to-back frames with no idle gap;
    - otherwise → IDLE.
- Baud counter:
  - Counts 0..`CLKS_PER_BIT`-1 and wraps to 0 on each bit boundary.
  - Width is $clog2(`CLKS_PER_BIT`); it never exceeds `CLKS_PER_BIT`-1.
- Pointers: `$clog2(FIFO_DEPTH)` bits each, wrapping naturally modulo `FIFO_DEPTH`.
- `tx` is a registered output with no combinational glitches.

## Timing

- Push to line: a push at edge N into an empty FIFO, with the FSM in IDLE, causes the pop at edge N+1. `tx` falls after edge N+1.
- Frame length: exactly 10×`CLKS_PER_BIT` cycles from `tx` falling to the end of STOP.
- Capacity: `FIFO_DEPTH` results can queue behind the frame in flight.
- `res_ready` and `fifo_count` reflect register state after the last edge; they carry no extra latency.
- `overflow` rises on the edge of the dropped push.
- Reset mid-frame: `tx` returns high immediately, and no partial frame resumes after reset release.

## Test plan

- Reset: assert `rst_n`=0 mid-frame → `tx`=1 immediately; `fifo_count`=0, `busy`=0, `overflow`=0. After release, `tx` stays high with no spurious frame.
- Single byte: `CLKS_PER_BIT`=4; push 0xA5 at edge 0 → `tx` is low from edge 1 for 4 cycles, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then high for 4. `busy` drops 40 cycles after edge 1.
- Back-to-back: push 0x01, 0x80, 0xFF on consecutive cycles → three frames, exactly 120 cycles in total, with no idle cycle between any STOP and the following START. Bytes are decoded in push order.
- Overflow: `FIFO_DEPTH`=4; push b0..b5 on six consecutive cycles starting at edge 0 → b5 is dropped at edge 5. `overflow`=1 from edge 5, and `fifo_count` peaks at 4. Exactly b0..b4 are transmitted, and `overflow` stays 1 afterwards.
- Simultaneous push/pop at full: FIFO holds 4 entries and a STOP is ending; push in the cycle of the pop → the push is accepted and `fifo_count` stays 4. `overflow` stays 0.
- Enable gating: `ena`=0 with `res_valid`=1 for 10 cycles → `fifo_count` stays 0 and `tx` stays high. Dropping `ena` mid-frame still completes that frame and drains the queued entries.

Source files
------------

// File: rtl/alu_result_uart_tx.sv
// Captures ALU result bytes into a small FIFO and replays them as 8N1 UART
// frames (LSB first) on a single registered output pin.
module alu_result_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        ena,
  input  logic [7:0]                  res_in,
  input  logic                        res_valid,
  output logic                        res_ready,
  output logic                        tx,
  output logic                        busy,
  output logic                        overflow,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int BAUD_W = $clog2(CLKS_PER_BIT);

  localparam logic [CNT_W-1:0]  FIFO_FULL = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [PTR_W-1:0]  PTR_ONE   = PTR_W'(1);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t             state;
  logic [BAUD_W-1:0]  baud_cnt;
  logic [2:0]         bit_idx;
  logic [7:0]         shift_reg;

  logic [7:0]         mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;

  logic               baud_end;
  logic               fifo_empty;
  logic               push_req;
  logic               pop;
  logic               push_ok;

  // A pop frees a slot on the same edge, so a full FIFO still accepts a push
  // that coincides with the transition into START.
  always_comb begin
    baud_end   = (baud_cnt == BAUD_LAST);
    fifo_empty = (fifo_count == '0);
    push_req   = res_valid && ena;
    pop        = !fifo_empty && ((state == IDLE) || ((state == STOP) && baud_end));
    push_ok    = push_req && ((fifo_count < FIFO_FULL) || pop);
  end

  assign res_ready = (fifo_count < FIFO_FULL);

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= res_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      if (push_ok && !pop) begin
        fifo_count <= fifo_count + CNT_ONE;
      end else if (!push_ok && pop) begin
        fifo_count <= fifo_count - CNT_ONE;
      end
      if (push_req && !push_ok) begin
        overflow <= 1'b1;
      end
    end
  end

  // tx always carries the level of the bit currently on the line; the next
  // data bit is taken from shift_reg[1] as the register shifts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      tx        <= 1'b1;
      busy      <= 1'b0;
      baud_cnt  <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            state     <= START;
            busy      <= 1'b1;
            tx        <= 1'b0;
            baud_cnt  <= '0;
            shift_reg <= mem[rd_ptr];
          end
        end

        START: begin
          if (baud_end) begin
            state    <= DATA;
            baud_cnt <= '0;
            bit_idx  <= '0;
            tx       <= shift_reg[0];
          end else begin
            baud_cnt <= baud_cnt + BAUD_ONE;
          end
        end

        DATA: begin
          if (baud_end) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
              state <= STOP;
              tx    <= 1'b1;
            end else begin
              bit_idx   <= bit_idx + 3'd1;
              tx        <= shift_reg[1];
              shift_reg <= {1'b0, shift_reg[7:1]};
            end
          end else begin
            baud_cnt <= baud_cnt + BAUD_ONE;
          end
        end

        STOP: begin
          if (baud_end) begin
            baud_cnt <= '0;
            if (pop) begin
              state     <= START;
              tx        <= 1'b0;
              shift_reg <= mem[rd_ptr];
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            baud_cnt <= baud_cnt + BAUD_ONE;
          end
        end

        default: begin
          state <= IDLE;
          tx    <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_result_uart_tx.sv
// Bench for alu_result_uart_tx: frame-timing vectors, a UART decoder feeding a
// byte scoreboard, and directed FIFO / overflow / enable / reset sequences.
module tb_alu_result_uart_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic [7:0] res_in = '0;
  logic       res_valid = 1'b0;
  logic       res_ready;
  logic       tx;
  logic       busy;
  logic       overflow;
  logic [2:0] fifo_count;

  int n_checks = 0;
  int n_fail   = 0;
  int rst_events = 0;
  logic [7:0] sb [$];

  alu_result_uart_tx #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .res_in    (res_in),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .tx        (tx),
    .busy      (busy),
    .overflow  (overflow),
    .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  always @(negedge rst_n) rst_events++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // UART decoder: samples mid-bit (bit = 40 time units) and checks against the scoreboard.
  initial begin
    logic [7:0] b;
    logic       start_lvl;
    logic       stop_lvl;
    int         rs;
    logic [7:0] exp_b;
    forever begin
      @(negedge tx);
      if (!rst_n) continue;
      rs = rst_events;
      #25 start_lvl = tx;
      for (int i = 0; i < 8; i++) begin
        #40 b[i] = tx;
      end
      #40 stop_lvl = tx;
      if (rs == rst_events) begin
        if (sb.size() == 0) begin
          check("mon_unexpected_frame", {24'd0, b}, 32'hFFFF_FFFF);
        end else begin
          exp_b = sb.pop_front();
          check("mon_byte", {24'd0, b}, {24'd0, exp_b});
          check("mon_start", {31'd0, start_lvl}, 32'd0);
          check("mon_stop", {31'd0, stop_lvl}, 32'd1);
        end
      end
    end
  end

  task automatic wait_idle();
    int i;
    i = 0;
    while (!(busy == 1'b0 && fifo_count == 3'd0) && i < 3000) begin
      @(posedge clk);
      #1;
      i++;
    end
    check("idle_timeout", {31'd0, (i >= 3000)}, 32'd0);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
  endtask

  typedef struct {
    logic [7:0] data;
    logic [9:0] exp_frame;
  } frame_vec_t;

  typedef struct {
    logic [7:0] data;
    logic [2:0] exp_count;
    logic       exp_ovf;
    logic       exp_ready;
  } ovf_vec_t;

  frame_vec_t fv [5];
  ovf_vec_t   ov [6];

  initial begin
    int cnt;
    int bad;
    logic [7:0] bb [3];

    fv[0] = '{8'hA5, 10'h34A};
    fv[1] = '{8'h00, 10'h200};
    fv[2] = '{8'hFF, 10'h3FE};
    fv[3] = '{8'h3C, 10'h278};
    fv[4] = '{8'h81, 10'h302};

    ov[0] = '{8'h11, 3'd1, 1'b0, 1'b1};
    ov[1] = '{8'h22, 3'd1, 1'b0, 1'b1};
    ov[2] = '{8'h33, 3'd2, 1'b0, 1'b1};
    ov[3] = '{8'h44, 3'd3, 1'b0, 1'b1};
    ov[4] = '{8'h55, 3'd4, 1'b0, 1'b0};
    ov[5] = '{8'h66, 3'd4, 1'b1, 1'b0};

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_tx", {31'd0, tx}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_ovf", {31'd0, overflow}, 32'd0);
    check("rst_count", {29'd0, fifo_count}, 32'd0);
    check("rst_ready", {31'd0, res_ready}, 32'd1);

    // Single frames: exact line level for each of the 10 bit slots.
    for (int v = 0; v < 5; v++) begin
      wait_idle();
      res_valid = 1'b1;
      res_in    = fv[v].data;
      sb.push_back(fv[v].data);
      @(posedge clk);
      #1 res_valid = 1'b0;
      @(posedge clk);
      for (int k = 0; k < 10; k++) begin
        repeat ((k == 0) ? 2 : 4) @(negedge clk);
        check($sformatf("frame%0d_bit%0d", v, k), {31'd0, tx}, {31'd0, fv[v].exp_frame[k]});
      end
      repeat (2) @(negedge clk);
      check("frame_busy_last", {31'd0, busy}, 32'd1);
      @(negedge clk);
      check("frame_busy_drop", {31'd0, busy}, 32'd0);
      check("frame_count_end", {29'd0, fifo_count}, 32'd0);
    end

    // Back-to-back: three frames with no idle gap, 120 busy cycles.
    wait_idle();
    bb[0] = 8'h01;
    bb[1] = 8'h80;
    bb[2] = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      res_valid = 1'b1;
      res_in    = bb[i];
      sb.push_back(bb[i]);
      @(posedge clk);
      #1;
    end
    res_valid = 1'b0;
    cnt = 2;
    while (busy && cnt < 500) begin
      @(posedge clk);
      #1;
      if (busy) cnt++;
    end
    check("b2b_busy_cycles", cnt, 32'd120);
    check("b2b_count_end", {29'd0, fifo_count}, 32'd0);

    // Overflow: six pushes on consecutive edges, the sixth is dropped.
    wait_idle();
    for (int i = 0; i < 6; i++) begin
      res_valid = 1'b1;
      res_in    = ov[i].data;
      if (i < 5) sb.push_back(ov[i].data);
      @(posedge clk);
      #1;
      check($sformatf("ovf_count%0d", i), {29'd0, fifo_count}, {29'd0, ov[i].exp_count});
      check($sformatf("ovf_flag%0d", i), {31'd0, overflow}, {31'd0, ov[i].exp_ovf});
      check($sformatf("ovf_ready%0d", i), {31'd0, res_ready}, {31'd0, ov[i].exp_ready});
    end
    res_valid = 1'b0;
    wait_idle();
    check("ovf_sticky", {31'd0, overflow}, 32'd1);

    // Reset mid-frame while overflow is set.
    res_valid = 1'b1;
    res_in    = 8'h5A;
    @(posedge clk);
    #1 res_in = 8'h77;
    @(posedge clk);
    #1 res_valid = 1'b0;
    repeat (15) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("mrst_tx", {31'd0, tx}, 32'd1);
    check("mrst_busy", {31'd0, busy}, 32'd0);
    check("mrst_count", {29'd0, fifo_count}, 32'd0);
    check("mrst_ovf", {31'd0, overflow}, 32'd0);
    check("mrst_ready", {31'd0, res_ready}, 32'd1);
    sb.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      #1;
      if (tx !== 1'b1 || busy !== 1'b0) bad++;
    end
    check("mrst_no_resume", bad, 32'd0);

    // Push accepted on the pop edge while full.
    for (int i = 0; i < 5; i++) begin
      res_valid = 1'b1;
      res_in    = 8'hC0 + 8'(i);
      sb.push_back(8'hC0 + 8'(i));
      @(posedge clk);
      #1;
    end
    res_valid = 1'b0;
    repeat (36) @(posedge clk);
    #1;
    check("full_count_pre", {29'd0, fifo_count}, 32'd4);
    check("full_ready_pre", {31'd0, res_ready}, 32'd0);
    check("full_busy_pre", {31'd0, busy}, 32'd1);
    res_valid = 1'b1;
    res_in    = 8'hC5;
    sb.push_back(8'hC5);
    @(posedge clk);
    #1 res_valid = 1'b0;
    check("full_count_pop", {29'd0, fifo_count}, 32'd4);
    check("full_ovf_pop", {31'd0, overflow}, 32'd0);
    check("full_tx_start", {31'd0, tx}, 32'd0);
    wait_idle();
    check("full_ovf_end", {31'd0, overflow}, 32'd0);

    // Enable gating: ignored pushes while idle, then mid-frame ena drop.
    ena       = 1'b0;
    res_valid = 1'b1;
    res_in    = 8'hEE;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (fifo_count !== 3'd0 || tx !== 1'b1) bad++;
    end
    check("ena_gate_idle", bad, 32'd0);
    ena = 1'b1;
    bb[0] = 8'h12;
    bb[1] = 8'h34;
    bb[2] = 8'h56;
    for (int i = 0; i < 3; i++) begin
      res_in = bb[i];
      sb.push_back(bb[i]);
      @(posedge clk);
      #1;
    end
    ena    = 1'b0;
    res_in = 8'h99;
    repeat (20) @(posedge clk);
    #1;
    check("ena_gate_count", {29'd0, fifo_count}, 32'd2);
    check("ena_gate_busy", {31'd0, busy}, 32'd1);
    wait_idle();
    check("ena_gate_drained", {29'd0, fifo_count}, 32'd0);
    check("ena_gate_ovf", {31'd0, overflow}, 32'd0);
    res_valid = 1'b0;
    ena       = 1'b1;

    repeat (10) @(posedge clk);
    #1;
    check("sb_empty", sb.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
